// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor: STAGES chunks of WIDTH/STAGES bits, carry registered between stages.
// Optional build macro PIPELINED_RCA_SAT_EN saturates sum to the signed extreme on overflow.
module pipelined_rca #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = WIDTH / STAGES;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_cfg_check
    $error("pipelined_rca: WIDTH must be a positive multiple of STAGES");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // The whole pipe moves as one; it only freezes when the output is held.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int IW = WIDTH - gi * CW;   // operand bits still pending at this stage
    localparam int LW = (gi + 1) * CW;     // sum bits completed after this stage

    logic [IW-1:0] a_in;
    logic [IW-1:0] b_in;
    logic          c_in;
    logic          v_in;
    logic [CW:0]   chunk;
    logic [LW-1:0] s_cat;
    logic [LW-1:0] s_next;
    logic          v_reg;
    logic          c_reg;
    logic [LW-1:0] s_reg;

    if (gi == 0) begin : g_head
      assign a_in  = a;
      assign b_in  = b_eff;
      assign c_in  = c0;
      assign v_in  = in_valid;
      assign s_cat = chunk[CW-1:0];
    end else begin : g_body
      assign a_in  = g_stage[gi-1].g_mid.a_up_reg;
      assign b_in  = g_stage[gi-1].g_mid.b_up_reg;
      assign c_in  = g_stage[gi-1].c_reg;
      assign v_in  = g_stage[gi-1].v_reg;
      assign s_cat = {chunk[CW-1:0], g_stage[gi-1].s_reg};
    end

    assign chunk = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};

    if (gi == STAGES - 1) begin : g_last
      logic ovf_next;
      logic ovf_reg;

      // Same-sign operands producing an opposite-sign result is exactly cin(MSB) ^ cout(MSB).
      assign ovf_next = (a_in[CW-1] == b_in[CW-1]) && (chunk[CW-1] != a_in[CW-1]);

`ifdef PIPELINED_RCA_SAT_EN
      assign s_next = ovf_next ? {a_in[CW-1], {(WIDTH-1){~a_in[CW-1]}}} : s_cat;
`else
      assign s_next = s_cat;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_reg <= 1'b0;
        end else if (en) begin
          ovf_reg <= ovf_next;
        end
      end
    end else begin : g_mid
      logic [IW-CW-1:0] a_up_reg;
      logic [IW-CW-1:0] b_up_reg;

      assign s_next = s_cat;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_up_reg <= '0;
          b_up_reg <= '0;
        end else if (en) begin
          a_up_reg <= a_in[IW-1:CW];
          b_up_reg <= b_in[IW-1:CW];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_reg <= 1'b0;
        c_reg <= 1'b0;
        s_reg <= '0;
      end else if (en) begin
        v_reg <= v_in;
        c_reg <= chunk[CW];
        s_reg <= s_next;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_reg;
  assign sum       = g_stage[STAGES-1].s_reg;
  assign cout      = g_stage[STAGES-1].c_reg;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_reg;

endmodule

// File: tb/tb_pipelined_rca.sv
// Bench for pipelined_rca: three configurations (8/2, 32/4, 16/1) checked against an arithmetic scoreboard.
module tb_pipelined_rca;
  localparam int N = 3;

  function automatic int w_of(input int i);
    case (i)
      0:       return 8;
      1:       return 32;
      default: return 16;
    endcase
  endfunction

  function automatic int s_of(input int i);
    case (i)
      0:       return 2;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          t;
    int          stalls;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_s [N];
  logic        out_ready_s[N];
  logic        cin_s      [N];
  logic        sub_s      [N];
  logic [31:0] a_s        [N];
  logic [31:0] b_s        [N];
  logic        in_ready_s [N];
  logic        out_valid_s[N];
  logic        cout_s     [N];
  logic        ovf_s      [N];
  logic [31:0] sum_s      [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int W = w_of(gi);
    localparam int S = s_of(gi);
    logic [W-1:0] sum_w;
    logic         rdy_w, ov_w, co_w, ovf_w;

    pipelined_rca #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid_s[gi]),
      .in_ready (rdy_w),
      .a        (a_s[gi][W-1:0]),
      .b        (b_s[gi][W-1:0]),
      .cin      (cin_s[gi]),
      .sub      (sub_s[gi]),
      .out_valid(ov_w),
      .out_ready(out_ready_s[gi]),
      .sum      (sum_w),
      .cout     (co_w),
      .ovf      (ovf_w)
    );

    assign in_ready_s[gi]  = rdy_w;
    assign out_valid_s[gi] = ov_w;
    assign cout_s[gi]      = co_w;
    assign ovf_s[gi]       = ovf_w;
    assign sum_s[gi]       = 32'(sum_w);
  end

  int          cyc = 0;
  int          nc = 0;
  int          nf = 0;
  int          stalls[N];
  int          pops  [N];
  logic        acc   [N];
  logic        hold  [N];
  logic [31:0] hsum  [N];
  logic        hco   [N];
  logic        hov   [N];
  ent_t        sb_q  [N][$];

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic ent_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    ent_t   e;
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua   = longint'({32'h0, a}) & m;
    longint ub   = longint'({32'h0, b}) & m;
    longint sa   = (ua >= half) ? ua - 2 * half : ua;
    longint sb   = (ub >= half) ? ub - 2 * half : ub;
    longint full, sres;
    e = '0;
    if (sub) begin
      full   = ua - ub;
      sres   = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      full   = ua + ub + (cin ? 1 : 0);
      sres   = sa + sb + (cin ? 1 : 0);
      e.cout = (full > m);
    end
    e.ovf = (sres >= half) || (sres < -half);
    e.sum = 32'(full & m);
`ifdef PIPELINED_RCA_SAT_EN
    if (e.ovf) e.sum = (sres > 0) ? 32'(half - 1) : 32'(half);
`endif
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nc++;
    assert (got === exp) else begin
      nf++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample at negedge, update scoreboard, return 1 time unit after posedge.
  task automatic cycle();
    ent_t e;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      acc[i] = 1'b0;
      chk($sformatf("d%0d in_ready", i), 32'(in_ready_s[i]), 32'(!out_valid_s[i] || out_ready_s[i]));
      if (hold[i]) begin
        chk($sformatf("d%0d stall out_valid", i), 32'(out_valid_s[i]), 32'd1);
        chk($sformatf("d%0d stall sum", i), sum_s[i], hsum[i]);
        chk($sformatf("d%0d stall cout/ovf", i), {30'd0, cout_s[i], ovf_s[i]}, {30'd0, hco[i], hov[i]});
      end
      if (out_valid_s[i] && out_ready_s[i]) begin
        if (sb_q[i].size() == 0) begin
          chk($sformatf("d%0d stale out_valid", i), 32'(out_valid_s[i]), 32'd0);
        end else begin
          e = sb_q[i].pop_front();
          pops[i]++;
          chk($sformatf("d%0d sum", i), sum_s[i], e.sum);
          chk($sformatf("d%0d cout", i), 32'(cout_s[i]), 32'(e.cout));
          chk($sformatf("d%0d ovf", i), 32'(ovf_s[i]), 32'(e.ovf));
          if (e.stalls == stalls[i])
            chk($sformatf("d%0d latency", i), 32'(cyc - e.t), 32'(s_of(i)));
        end
      end
      hold[i] = out_valid_s[i] && !out_ready_s[i] && !rst;
      if (hold[i]) begin
        stalls[i]++;
        hsum[i] = sum_s[i];
        hco[i]  = cout_s[i];
        hov[i]  = ovf_s[i];
      end
      if (in_valid_s[i] && in_ready_s[i] && !rst) begin
        e        = model(w_of(i), a_s[i], b_s[i], cin_s[i], sub_s[i]);
        e.t      = cyc;
        e.stalls = stalls[i];
        sb_q[i].push_back(e);
        acc[i] = 1'b1;
      end
      if (rst) sb_q[i].delete();
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input int i, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub);
    in_valid_s[i] = 1'b1;
    a_s[i] = a; b_s[i] = b; cin_s[i] = cin; sub_s[i] = sub;
    cycle();
    in_valid_s[i] = 1'b0;
  endtask

  initial begin
    int p0, k, acc_n;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b0; cin_s[i] = 1'b0; sub_s[i] = 1'b0;
      a_s[i] = '0; b_s[i] = '0; stalls[i] = 0; pops[i] = 0; hold[i] = 1'b0; acc[i] = 1'b0;
    end

    // Reset state
    cycle(); cycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("d%0d reset in_ready", i), 32'(in_ready_s[i]), 32'd1);
      chk($sformatf("d%0d reset out_valid", i), 32'(out_valid_s[i]), 32'd0);
      chk($sformatf("d%0d reset sum", i), sum_s[i], 32'd0);
      chk($sformatf("d%0d reset cout/ovf", i), {30'd0, cout_s[i], ovf_s[i]}, 32'd0);
      out_ready_s[i] = 1'b1;
    end

    // 8/2 directed: signed overflow, all-ones + 1, 0 - 1
    send(0, 32'h3C, 32'h47, 1'b1, 1'b0);
    cycle();
    chk("d0 3C+47 out_valid", 32'(out_valid_s[0]), 32'd1);
`ifdef PIPELINED_RCA_SAT_EN
    chk("d0 3C+47 sum", sum_s[0], 32'h7F);
`else
    chk("d0 3C+47 sum", sum_s[0], 32'h84);
`endif
    chk("d0 3C+47 cout/ovf", {30'd0, cout_s[0], ovf_s[0]}, 32'b01);
    send(0, 32'hFF, 32'h01, 1'b0, 1'b0);
    cycle();
    chk("d0 FF+01 sum", sum_s[0], 32'h00);
    chk("d0 FF+01 cout/ovf", {30'd0, cout_s[0], ovf_s[0]}, 32'b10);
    send(0, 32'h00, 32'h01, 1'b0, 1'b1);
    cycle();
    chk("d0 00-01 sum", sum_s[0], 32'hFF);
    chk("d0 00-01 cout/ovf", {30'd0, cout_s[0], ovf_s[0]}, 32'b00);
    repeat (3) cycle();

    // 32/4 back-to-back stream
    for (int i = 0; i < 16; i++) begin
      in_valid_s[1] = 1'b1;
      a_s[1] = 32'(i) * 32'h11111111; b_s[1] = 32'h0F0F0F0F; cin_s[1] = 1'b0; sub_s[1] = 1'b0;
      chk("d1 stream in_ready", 32'(in_ready_s[1]), 32'd1);
      cycle();
    end
    in_valid_s[1] = 1'b0;
    repeat (6) cycle();
    chk("d1 stream delivered", 32'(pops[1]), 32'd16);

    // 32/4 backpressure mid-stream
    p0 = pops[1]; k = 0;
    a_s[1] = $urandom; b_s[1] = $urandom; cin_s[1] = 1'($urandom); sub_s[1] = 1'($urandom);
    for (int c = 0; c < 60 && k < 8; c++) begin
      in_valid_s[1]  = 1'b1;
      out_ready_s[1] = !(c >= 4 && c < 9);
      cycle();
      if (acc[1]) begin
        k++;
        a_s[1] = $urandom; b_s[1] = $urandom; cin_s[1] = 1'($urandom); sub_s[1] = 1'($urandom);
      end
    end
    in_valid_s[1] = 1'b0; out_ready_s[1] = 1'b1;
    repeat (8) cycle();
    chk("d1 backpressure delivered", 32'(pops[1] - p0), 32'd8);

    // 32/4 reset with three beats in flight
    p0 = pops[1];
    for (int i = 0; i < 3; i++) send(1, $urandom, $urandom, 1'b0, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("d1 flush out_valid", 32'(out_valid_s[1]), 32'd0);
    chk("d1 flush sum", sum_s[1], 32'd0);
    repeat (6) cycle();
    chk("d1 flush no output", 32'(pops[1] - p0), 32'd0);
    send(1, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
    repeat (5) cycle();
    chk("d1 post-reset delivered", 32'(pops[1] - p0), 32'd1);

    // 16/1 random (plus 8/2 alongside) with random valid and backpressure
    acc_n = 0;
    for (int c = 0; c < 6000 && acc_n < 1000; c++) begin
      for (int i = 0; i < N; i += 2) begin
        in_valid_s[i]  = ($urandom_range(0, 3) != 0);
        out_ready_s[i] = ($urandom_range(0, 3) != 0);
        a_s[i] = $urandom; b_s[i] = $urandom;
        cin_s[i] = 1'($urandom); sub_s[i] = 1'($urandom);
      end
      cycle();
      if (acc[2]) acc_n++;
    end
    chk("d2 random beats accepted", 32'(acc_n), 32'd1000);
    for (int i = 0; i < N; i++) begin
      in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b1;
    end
    repeat (8) cycle();
    for (int i = 0; i < N; i++)
      chk($sformatf("d%0d scoreboard drained", i), 32'(sb_q[i].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end
endmodule
